// File: rtl/tx_ctl.sv
// UART transmit controller: byte FIFO, holding register and shift register driving txd as 8N1.
// Defining TX_PARITY_EN adds an even-parity bit after the data bits (8E1).
module tx_ctl #(
    parameter int DEPTH     = 16,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bclk,
    input  logic       wr,
    input  logic [7:0] din,
    input  logic       en,
    input  logic       cts,
    output logic       txd,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    thr_q, thr_d;
    logic          thr_vld_q, thr_vld_d;
    logic [7:0]    tsr_q, tsr_d;
    logic [2:0]    bit_q, bit_d;
    logic          stop_q, stop_d;
    state_t        state_q, state_d;
    logic          txd_q, txd_d;
    logic          ovf_q, full_q, empty_q, busy_q;
    logic          push_s, pop_s, full_s, start_ok_s, load_s, last_stop_s;
`ifdef TX_PARITY_EN
    logic          par_q, par_d;
`endif

    // FIFO bookkeeping and holding-register prefetch
    always_comb begin
        full_s     = (cnt_q == CW'(DEPTH));
        pop_s      = ~thr_vld_q & (cnt_q != {CW{1'b0}});
        // A pop frees a slot in the same cycle, so a push while full is accepted then
        push_s     = wr & (~full_s | pop_s);
        wptr_d     = push_s ? (wptr_q + PW'(1)) : wptr_q;
        rptr_d     = pop_s ? (rptr_q + PW'(1)) : rptr_q;
        cnt_d      = cnt_q + CW'(push_s) - CW'(pop_s);
        thr_d      = pop_s ? mem_q[rptr_q] : thr_q;
        start_ok_s = thr_vld_q & en & cts;
        if (load_s) begin
            thr_vld_d = 1'b0;
        end else if (pop_s) begin
            thr_vld_d = 1'b1;
        end else begin
            thr_vld_d = thr_vld_q;
        end
    end

    // Frame sequencer: next state, shift register and line value
    always_comb begin
        state_d     = state_q;
        txd_d       = txd_q;
        tsr_d       = tsr_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        load_s      = 1'b0;
        last_stop_s = (STOP_BITS == 1) ? 1'b1 : stop_q;
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (bclk && start_ok_s) begin
                    load_s  = 1'b1;
                    tsr_d   = thr_q;
                    txd_d   = 1'b0;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bclk) begin
                    txd_d   = tsr_q[0];
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (bclk) begin
                    if (bit_q == 3'd7) begin
`ifdef TX_PARITY_EN
                        txd_d   = par_q;
                        state_d = S_PARITY;
`else
                        txd_d   = 1'b1;
                        stop_d  = 1'b0;
                        state_d = S_STOP;
`endif
                    end else begin
                        tsr_d = {1'b0, tsr_q[7:1]};
                        txd_d = tsr_q[1];
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef TX_PARITY_EN
            S_PARITY: begin
                if (bclk) begin
                    txd_d   = 1'b1;
                    stop_d  = 1'b0;
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (bclk) begin
                    if (!last_stop_s) begin
                        stop_d = 1'b1;
                    end else if (start_ok_s) begin
                        // Back-to-back frame: the start bit follows the stop bit directly
                        load_s  = 1'b1;
                        tsr_d   = thr_q;
                        txd_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

`ifdef TX_PARITY_EN
    // Even parity captured as the byte enters the shift register
    always_comb begin
        par_d = load_s ? (^thr_q) : par_q;
    end
`endif

    // FIFO storage, written without reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= din;
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= {PW{1'b0}};
            rptr_q    <= {PW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            thr_q     <= 8'h00;
            thr_vld_q <= 1'b0;
            tsr_q     <= 8'h00;
            bit_q     <= 3'd0;
            stop_q    <= 1'b0;
            state_q   <= S_IDLE;
            txd_q     <= 1'b1;
            ovf_q     <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            busy_q    <= 1'b0;
`ifdef TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            thr_q     <= thr_d;
            thr_vld_q <= thr_vld_d;
            tsr_q     <= tsr_d;
            bit_q     <= bit_d;
            stop_q    <= stop_d;
            state_q   <= state_d;
            txd_q     <= txd_d;
            ovf_q     <= wr & full_s & ~pop_s;
            full_q    <= (cnt_d == CW'(DEPTH));
            empty_q   <= (cnt_d == {CW{1'b0}});
            busy_q    <= (state_d != S_IDLE) | thr_vld_d;
`ifdef TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign txd   = txd_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign busy  = busy_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_tx_ctl.sv
// Bench for tx_ctl: bytes pushed are queued as expected frames; a line monitor decodes txd and compares.
module tb_tx_ctl;

    localparam int STOP_BITS = 1;

    logic       clk = 1'b0;
    logic       rst, bclk, wr, en, cts;
    logic [7:0] din;
    logic       txd, full, empty, busy, ovf;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q [$];

    tx_ctl #(.DEPTH(16), .STOP_BITS(STOP_BITS)) dut (
        .clk(clk), .rst(rst), .bclk(bclk), .wr(wr), .din(din), .en(en), .cts(cts),
        .txd(txd), .full(full), .empty(empty), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    // Baud tick: one clk wide, every 16 clk
    int div = 0;
    initial begin
        bclk = 1'b0;
        forever begin
            @(negedge clk);
            div  = (div + 1) % 16;
            bclk = (div == 0);
        end
    end

    // Line monitor: samples txd once per bit interval, just after each baud edge
    logic       tick_q = 1'b0;
    logic       rst_q  = 1'b0;
    int         mstate = 0;
    int         nb     = 0;
    int         gap    = 0;
    int         last_gap = -1;
    int         frames = 0;
    logic [7:0] sh     = 8'h00;
    logic       par_seen = 1'b0;
    logic [7:0] expb;

    always @(posedge clk) begin
        tick_q <= bclk;
        rst_q  <= rst;
    end

    always @(negedge clk) begin
        if (rst_q) begin
            mstate = 0;
            nb     = 0;
            gap    = 0;
        end else if (tick_q) begin
            case (mstate)
                0: begin
                    if (txd === 1'b0) begin
                        last_gap = gap;
                        mstate   = 1;
                        nb       = 0;
                    end else begin
                        gap++;
                    end
                end
                1: begin
                    sh = {txd, sh[7:1]};
                    nb++;
                    if (nb == 8) begin
`ifdef TX_PARITY_EN
                        mstate = 2;
`else
                        mstate = 3;
`endif
                        nb = 0;
                    end
                end
                2: begin
                    par_seen = txd;
                    mstate   = 3;
                end
                default: begin
                    chk("stop_bit", {31'd0, txd}, 32'd1);
                    nb++;
                    if (nb == STOP_BITS) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_frame", {24'd0, sh}, 32'hFFFF_FFFF);
                        end else begin
                            expb = exp_q.pop_front();
                            chk("frame_data", {24'd0, sh}, {24'd0, expb});
`ifdef TX_PARITY_EN
                            chk("parity_bit", {31'd0, par_seen}, {31'd0, ^expb});
`endif
                        end
                        frames++;
                        mstate = 0;
                        nb     = 0;
                        gap    = 0;
                    end
                end
            endcase
        end
    end

    // Drive one write for one cycle; leaves wr high so consecutive calls are back to back
    task automatic push(input logic [7:0] b, input bit accepted);
        wr  = 1'b1;
        din = b;
        if (accepted) exp_q.push_back(b);
        @(negedge clk);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int t = 0;
        while (frames < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("frames_done", frames, target);
    endtask

    task automatic wait_bclk_edge();
        do @(posedge clk); while (bclk !== 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        rst = 1'b1; wr = 1'b0; din = 8'h00; en = 1'b1; cts = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Single byte with minimum latency: write sampled 2 clk before a baud edge
        wait_bclk_edge();
        repeat (14) @(negedge clk);
        push(8'h55, 1'b1);
        wr = 1'b0;
        @(negedge clk);
        chk("lat_txd_before", {31'd0, txd}, 32'd1);
        @(negedge clk);
        chk("lat_txd_start", {31'd0, txd}, 32'd0);
        wait_frames(1, 400);
        chk("busy_in_stop", {31'd0, busy}, 32'd1);
        wait_bclk_edge();
        @(negedge clk);
        chk("busy_after_stop", {31'd0, busy}, 32'd0);
        chk("idle_txd", {31'd0, txd}, 32'd1);

        // Back-to-back frames: no idle interval between them
        push(8'hA3, 1'b1);
        push(8'h0F, 1'b1);
        wr = 1'b0;
        wait_frames(3, 800);
        chk("b2b_gap", last_gap, 32'd0);
        repeat (40) @(negedge clk);

        // Flow control: cts low holds off the start; dropping it mid-frame does not truncate
        cts = 1'b0;
        push(8'h81, 1'b1);
        wr = 1'b0;
        repeat (5) wait_bclk_edge();
        @(negedge clk);
        chk("cts_hold_txd", {31'd0, txd}, 32'd1);
        chk("cts_hold_frames", frames, 32'd3);
        cts = 1'b1;
        wait_bclk_edge();
        @(negedge clk);
        chk("cts_start", {31'd0, txd}, 32'd0);
        repeat (40) @(negedge clk);
        cts = 1'b0;
        wait_frames(4, 400);
        cts = 1'b1;
        repeat (40) @(negedge clk);

        // Fill FIFO plus THR with transmit disabled, then overflow once
        en = 1'b0;
        base = frames;
        for (int i = 0; i < 17; i++) begin
            push(8'(8'h10 + i), 1'b1);
            if (i == 15) chk("full_after_16", {31'd0, full}, 32'd0);
        end
        chk("full_after_17", {31'd0, full}, 32'd1);
        chk("ovf_before", {31'd0, ovf}, 32'd0);
        push(8'hEE, 1'b0);
        wr = 1'b0;
        chk("ovf_pulse", {31'd0, ovf}, 32'd1);
        @(negedge clk);
        chk("ovf_clear", {31'd0, ovf}, 32'd0);
        chk("still_full", {31'd0, full}, 32'd1);
        en = 1'b1;
        wait_frames(base + 17, 17 * 16 * 12 + 400);
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_queue", exp_q.size(), 32'd0);
        repeat (40) @(negedge clk);

        // Reset during data bit 3 (a zero bit), with bytes still queued
        push(8'hF0, 1'b1);
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        wr = 1'b0;
        t = 0;
        while (!(mstate == 1 && nb == 4) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("reach_bit3", {31'd0, (t < 1000)}, 32'd1);
        chk("bit3_low", {31'd0, txd}, 32'd0);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_txd", {31'd0, txd}, 32'd1);
        chk("midrst_empty", {31'd0, empty}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        base = frames;
        push(8'h3C, 1'b1);
        wr = 1'b0;
        wait_frames(base + 1, 400);

`ifdef TX_PARITY_EN
        base = frames;
        push(8'h07, 1'b1);
        push(8'h03, 1'b1);
        wr = 1'b0;
        wait_frames(base + 2, 800);
`endif

        repeat (40) @(negedge clk);
        chk("final_queue", exp_q.size(), 32'd0);
        chk("final_busy", {31'd0, busy}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
